uart_rx_ctrl: RTL and testbench

//   Controller/buffer behind the UART receive shift register. Gates the receiver on/off,

---
 rtl/uart_rx_ctrl_if.sv | 28 ++
 rtl/uart_rx_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_ctrl_if.sv
// Handshake bundle between the host side and the UART receive controller.
// master drives control/strobe/pop; slave (the controller) returns status and FIFO head.
interface uart_rx_ctrl_if #(
    parameter int unsigned DEPTH_LOG2 = 3
);
    logic                  enable;
    logic                  flush;
    logic [7:0]            rx_byte;
    logic                  rx_rdy;
    logic                  rd_en;
    logic                  rx_on;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  full;
    logic [DEPTH_LOG2:0]   level;
    logic                  overrun;
    logic                  timeout;

    modport master (
        output enable, flush, rx_byte, rx_rdy, rd_en,
        input  rx_on, rd_data, rd_valid, full, level, overrun, timeout
    );

    modport slave (
        input  enable, flush, rx_byte, rx_rdy, rd_en,
        output rx_on, rd_data, rd_valid, full, level, overrun, timeout
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: receiver gating FSM, edge-captured byte FIFO with FWFT read.
// Optional idle-data timeout counter is built only when UART_RXCTRL_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned DEPTH_LOG2 = 3,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic          bclk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PW    = DEPTH_LOG2;
    localparam int unsigned LW    = DEPTH_LOG2 + 1;

    if (DEPTH_LOG2 < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("uart_rx_ctrl: DEPTH_LOG2 and TIMEOUT must both be >= 1");
    end

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            rx_rdy_q, rx_rdy_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic            overrun_q, overrun_d;
    logic            rx_on_q, rx_on_d;
    logic            rd_valid_q, rd_valid_d;
    logic            full_q, full_d;
    logic [7:0]      rd_data_q, rd_data_d;
    logic [7:0]      mem_q [DEPTH];

    logic            flush_go;
    logic            wr;
    logic            wr_do;
    logic            pop;

    // Flush is only accepted from OFF/RUN; its entry cycle swallows writes and pops.
    assign flush_go = bus.flush & (state_q != ST_FLUSH);
    assign wr       = bus.rx_rdy & ~rx_rdy_q & (state_q == ST_RUN) & ~flush_go;
    assign pop      = bus.rd_en & rd_valid_q & ~flush_go;
    assign wr_do    = wr & (~full_q | pop);

    // Next-state logic; flush takes priority over enable.
    always_comb begin
        state_d = state_q;
        rx_on_d = 1'b0;
        case (state_q)
            ST_OFF:   state_d = bus.enable ? ST_RUN : ST_OFF;
            ST_RUN:   state_d = bus.enable ? ST_RUN : ST_OFF;
            ST_FLUSH: state_d = bus.enable ? ST_RUN : ST_OFF;
            default:  state_d = ST_OFF;
        endcase
        if (flush_go) begin
            state_d = ST_FLUSH;
        end
        rx_on_d = (state_d == ST_RUN);
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_OFF;
            rx_on_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_on_q <= rx_on_d;
        end
    end

    // FIFO pointer/level/flag update; status outputs are registered from next-state values.
    always_comb begin
        rx_rdy_d   = bus.rx_rdy;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overrun_d  = overrun_q;
        rd_valid_d = 1'b0;
        full_d     = 1'b0;
        rd_data_d  = 8'h00;

        if (flush_go) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            level_d   = '0;
            overrun_d = 1'b0;
        end else begin
            if (wr_do) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (wr && !wr_do) begin
                overrun_d = 1'b1;
            end
            if (wr_do && !pop) begin
                level_d = level_q + LW'(1);
            end else if (pop && !wr_do) begin
                level_d = level_q - LW'(1);
            end
        end

        rd_valid_d = (level_d != '0);
        full_d     = (level_d == LW'(DEPTH));
        // Head lands on the slot being written this edge when the write becomes the new head.
        if (rd_valid_d) begin
            if (wr_do && (wr_ptr_q == rd_ptr_d)) begin
                rd_data_d = bus.rx_byte;
            end else begin
                rd_data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            rx_rdy_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overrun_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            full_q     <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            rx_rdy_q   <= rx_rdy_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overrun_q  <= overrun_d;
            rd_valid_q <= rd_valid_d;
            full_q     <= full_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Byte storage is deliberately left unreset.
    always_ff @(posedge bclk) begin
        if (wr_do) begin
            mem_q[wr_ptr_q] <= bus.rx_byte;
        end
    end

`ifdef UART_RXCTRL_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          timeout_q, timeout_d;

    // Idle counter runs only while data is waiting in RUN, saturating at TIMEOUT.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        timeout_d = 1'b0;
        if (wr || pop || flush_go || (level_q == '0)) begin
            tmo_cnt_d = '0;
        end else if ((state_q == ST_RUN) && (tmo_cnt_q != TW'(TIMEOUT))) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
        timeout_d = (tmo_cnt_d == TW'(TIMEOUT));
    end

    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    assign bus.rx_on    = rx_on_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (DEPTH_LOG2=3, TIMEOUT=16) with hand-computed expectations.
// Timeout expectation follows whether UART_RXCTRL_TIMEOUT_EN is defined for the build.
module tb_uart_rx_ctrl;
`ifdef UART_RXCTRL_TIMEOUT_EN
    localparam logic TMO_ON = 1'b1;
`else
    localparam logic TMO_ON = 1'b0;
`endif

    logic bclk;
    logic rst;
    int   checks;
    int   errors;

    uart_rx_ctrl_if #(.DEPTH_LOG2(3)) bus ();

    uart_rx_ctrl #(.DEPTH_LOG2(3), .TIMEOUT(16)) dut (
        .bclk (bclk),
        .rst  (rst),
        .bus  (bus)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    task automatic tick();
        @(posedge bclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] b);
        bus.rx_byte = b;
        bus.rx_rdy  = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
        tick();
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.flush   = 1'b0;
        bus.rx_byte = 8'h00;
        bus.rx_rdy  = 1'b0;
        bus.rd_en   = 1'b0;
        tick();
        tick();
        chk("rst_rx_on",    32'(bus.rx_on),    32'd0);
        chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_overrun",  32'(bus.overrun),  32'd0);
        chk("rst_timeout",  32'(bus.timeout),  32'd0);
        chk("rst_rd_data",  32'(bus.rd_data),  32'h00);
        rst = 1'b0;

        // Basic capture and FWFT pop
        bus.enable = 1'b1;
        tick();
        chk("t1_rx_on", 32'(bus.rx_on), 32'd1);
        strobe(8'hA5);
        strobe(8'h3C);
        chk("t1_level2",   32'(bus.level),    32'd2);
        chk("t1_head_a5",  32'(bus.rd_data),  32'hA5);
        chk("t1_valid",    32'(bus.rd_valid), 32'd1);
        pop();
        chk("t1_head_3c",  32'(bus.rd_data),  32'h3C);
        chk("t1_level1",   32'(bus.level),    32'd1);
        pop();
        chk("t1_level0",   32'(bus.level),    32'd0);
        chk("t1_empty",    32'(bus.rd_valid), 32'd0);
        chk("t1_gated",    32'(bus.rd_data),  32'h00);

        // Held strobe writes once
        bus.rx_byte = 8'h11;
        bus.rx_rdy  = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.rx_rdy  = 1'b0;
        tick();
        chk("t2_level1", 32'(bus.level),   32'd1);
        chk("t2_head",   32'(bus.rd_data), 32'h11);
        pop();
        chk("t2_level0", 32'(bus.level),   32'd0);

        // Fill, overrun, drain, pointer wrap
        for (int i = 0; i < 8; i++) strobe(8'(i));
        chk("t3_full8",     32'(bus.full),    32'd1);
        chk("t3_no_ovr",    32'(bus.overrun), 32'd0);
        strobe(8'h08);
        chk("t3_level8",    32'(bus.level),   32'd8);
        chk("t3_overrun",   32'(bus.overrun), 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("t3_drain", 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("t3_drained",   32'(bus.level),   32'd0);
        chk("t3_ovr_stick", 32'(bus.overrun), 32'd1);
        for (int k = 0; k < 20; k++) begin
            strobe(8'h40 + 8'(k));
            chk("t3_wrap_data", 32'(bus.rd_data), 32'h40 + 32'(k));
            pop();
            chk("t3_wrap_lvl",  32'(bus.level),   32'd0);
        end

        // Plain flush clears overrun; rx_on drops for one cycle
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("fl_overrun", 32'(bus.overrun), 32'd0);
        chk("fl_rx_on0",  32'(bus.rx_on),   32'd0);
        tick();
        chk("fl_rx_on1",  32'(bus.rx_on),   32'd1);

        // Full FIFO with simultaneous write and pop
        for (int i = 0; i < 8; i++) strobe(8'h80 + 8'(i));
        chk("t4_full", 32'(bus.full), 32'd1);
        bus.rx_byte = 8'hEE;
        bus.rx_rdy  = 1'b1;
        bus.rd_en   = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
        bus.rd_en   = 1'b0;
        chk("t4_level8",  32'(bus.level),   32'd8);
        chk("t4_no_ovr",  32'(bus.overrun), 32'd0);
        chk("t4_full2",   32'(bus.full),    32'd1);
        chk("t4_head",    32'(bus.rd_data), 32'h81);
        tick();
        for (int i = 1; i < 8; i++) begin
            chk("t4_drain", 32'(bus.rd_data), 32'h80 + 32'(i));
            pop();
        end
        chk("t4_last", 32'(bus.rd_data), 32'hEE);
        pop();
        chk("t4_empty", 32'(bus.rd_valid), 32'd0);

        // Flush beats concurrent strobe and pop
        for (int i = 0; i < 9; i++) strobe(8'hC0 + 8'(i));
        for (int i = 0; i < 5; i++) pop();
        chk("t5_level3", 32'(bus.level),   32'd3);
        chk("t5_ovr1",   32'(bus.overrun), 32'd1);
        chk("t5_head",   32'(bus.rd_data), 32'hC5);
        bus.rx_byte = 8'h77;
        bus.rx_rdy  = 1'b1;
        bus.rd_en   = 1'b1;
        bus.flush   = 1'b1;
        tick();
        bus.rx_rdy  = 1'b0;
        bus.rd_en   = 1'b0;
        bus.flush   = 1'b0;
        chk("t5_level0", 32'(bus.level),    32'd0);
        chk("t5_valid0", 32'(bus.rd_valid), 32'd0);
        chk("t5_ovr0",   32'(bus.overrun),  32'd0);
        chk("t5_rx_on0", 32'(bus.rx_on),    32'd0);
        chk("t5_data0",  32'(bus.rd_data),  32'h00);
        tick();
        chk("t5_rx_on1", 32'(bus.rx_on),    32'd1);
        chk("t5_nowr",   32'(bus.level),    32'd0);

        // OFF gates capture but keeps contents readable; pop on empty is ignored
        strobe(8'h33);
        bus.enable = 1'b0;
        tick();
        chk("off_rx_on", 32'(bus.rx_on), 32'd0);
        strobe(8'h44);
        chk("off_nowr",  32'(bus.level),   32'd1);
        chk("off_head",  32'(bus.rd_data), 32'h33);
        pop();
        chk("off_pop",   32'(bus.level),   32'd0);
        pop();
        chk("off_empty_pop", 32'(bus.level), 32'd0);
        bus.enable = 1'b1;
        tick();
        chk("on_again", 32'(bus.rx_on), 32'd1);

        // Idle timeout: asserted 16 cycles after the write edge
        strobe(8'h5A);
        for (int i = 0; i < 14; i++) tick();
        chk("tmo_before", 32'(bus.timeout), 32'd0);
        tick();
        chk("tmo_at16",   32'(bus.timeout), 32'(TMO_ON));
        tick();
        chk("tmo_hold",   32'(bus.timeout), 32'(TMO_ON));
        pop();
        chk("tmo_clear",  32'(bus.timeout), 32'd0);
        chk("tmo_level",  32'(bus.level),   32'd0);

        // Asynchronous reset mid-operation
        strobe(8'h99);
        chk("ar_level1", 32'(bus.level), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_level",  32'(bus.level),    32'd0);
        chk("ar_valid",  32'(bus.rd_valid), 32'd0);
        chk("ar_rx_on",  32'(bus.rx_on),    32'd0);
        chk("ar_data",   32'(bus.rd_data),  32'h00);
        rst = 1'b0;
        tick();
        chk("ar_run", 32'(bus.rx_on), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
